// File: rtl/sram_rd_ctrl_if.sv
// Request, SRAM-side and response signals of the SRAM read controller.
// The slave modport is the controller; the master modport is its environment.
interface sram_rd_ctrl_if #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned WADDR_W = 8
);
    logic               req_valid;
    logic               req_ready;
    logic [ADDR_W-1:0]  req_addr;
    logic [1:0]         req_conf;
    logic               sram_ren;
    logic [WADDR_W-1:0] sram_addr;
    logic [1:0]         mux_conf;
    logic [1:0]         mux_addr;
    logic [31:0]        mux_data;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [31:0]        rsp_data;
    logic               rsp_err;

    modport slave (
        input  req_valid, req_addr, req_conf, mux_data, rsp_ready,
        output req_ready, sram_ren, sram_addr, mux_conf, mux_addr,
               rsp_valid, rsp_data, rsp_err
    );

    modport master (
        output req_valid, req_addr, req_conf, mux_data, rsp_ready,
        input  req_ready, sram_ren, sram_addr, mux_conf, mux_addr,
               rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/sram_rd_ctrl.sv
// Read controller for a one-cycle-latency SRAM: splits element addresses into
// word/lane, steers the data-out mux, and queues responses in a 2-entry FIFO.
module sram_rd_ctrl #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned WADDR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    sram_rd_ctrl_if.slave    bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 2;
    localparam int unsigned ENT_W  = DATA_W + 1;

    logic [ADDR_W-1:0]  addr;
    logic [WADDR_W-1:0] word_c;
    logic [1:0]         conf_c;
    logic [1:0]         lane_c;
    logic               err_c;

    logic               inflight;
    logic               infl_err;
    logic [1:0]         mux_conf_q;
    logic [1:0]         mux_addr_q;
    logic [1:0]         cnt;
    logic [1:0]         occ;
    logic               wptr;
    logic               rptr;
    logic [ENT_W-1:0]   mem [DEPTH];

    logic               ready_c;
    logic               accept;
    logic               push;
    logic               pop;

    assign addr = bus.req_addr;

    // Element address -> SRAM word and lane; reserved conf reads a full word
    always_comb begin
        word_c = WADDR_W'(addr);
        conf_c = 2'b00;
        lane_c = 2'b00;
        err_c  = 1'b0;
        case (bus.req_conf)
            2'b01: begin
                word_c = WADDR_W'(addr >> 1);
                conf_c = 2'b01;
                lane_c = {1'b0, addr[0]};
            end
            2'b10: begin
                word_c = WADDR_W'(addr >> 2);
                conf_c = 2'b10;
                lane_c = addr[1:0];
            end
            2'b11: err_c = 1'b1;
            default: ;
        endcase
    end

    // Credits: every accepted read owns a FIFO slot until its response pops
    assign occ     = cnt + {1'b0, inflight};
    assign ready_c = !rst && (occ < 2'd2);
    assign accept  = bus.req_valid && ready_c;
    assign push    = inflight;
    assign pop     = (cnt != 2'd0) && bus.rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight   <= 1'b0;
            infl_err   <= 1'b0;
            mux_conf_q <= 2'b00;
            mux_addr_q <= 2'b00;
            cnt        <= 2'd0;
            wptr       <= 1'b0;
            rptr       <= 1'b0;
        end else begin
            inflight <= accept;
            if (accept) begin
                infl_err   <= err_c;
                mux_conf_q <= conf_c;
                mux_addr_q <= lane_c;
            end
            if (push) wptr <= ~wptr;
            if (pop)  rptr <= ~rptr;
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: ;
            endcase
        end
    end

    // Response storage; reset gating keeps a late mux_data out of the FIFO
    always_ff @(posedge clk) begin
        if (!rst && push) mem[wptr] <= {infl_err, bus.mux_data};
    end

    assign bus.req_ready = ready_c;
    assign bus.sram_ren  = accept;
    assign bus.sram_addr = word_c;
    assign bus.mux_conf  = mux_conf_q;
    assign bus.mux_addr  = mux_addr_q;
    assign bus.rsp_valid = (cnt != 2'd0);
    assign bus.rsp_data  = mem[rptr][DATA_W-1:0];
    assign bus.rsp_err   = (cnt != 2'd0) && mem[rptr][DATA_W];
endmodule
